shape_dispatcher: RTL and testbench
===================================

Name: shape_dispatcher

Overview:
- Frame-level initiator that drives the pixel-drawing FSM's start/done handshake.
- On each frame tick it snapshots up to NUM_SHAPES note-slot records (valid flag, X/Y origin).
- For each valid slot, in ascending index order, it presents the origin, pulses startingAddressLoaded, and waits for the drawer to go busy and then return done.
- Sits between the game/note-lane logic and the draw FSM; reports frame completion, frame overrun and drawer timeout.

Parameters:
- NUM_SHAPES, 4, number of shape slots walked per frame (2..16).
- X_WIDTH, 8, width of the X origin.
- Y_WIDTH, 7, width of the Y origin.
- TIMEOUT, 4095, max consecutive cycles spent waiting on shapeDone per slot (≥2).
- IDX_WIDTH, 3, width of shapeIndex; must hold values 0..NUM_SHAPES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- frameTick  in  1  one-cycle request to draw a frame
- slotValid  in  NUM_SHAPES  per-slot enable; bit i = slot i
- slotX  in  NUM_SHAPES*X_WIDTH  packed X origins; slot i at [i*X_WIDTH +: X_WIDTH]
- slotY  in  NUM_SHAPES*Y_WIDTH  packed Y origins; same packing
- shapeDone  in  1  drawer done/idle level (high while drawer idle)
- startingAddressLoaded  out  1  one-cycle start pulse to drawer
- startX  out  X_WIDTH  origin X presented to drawer
- startY  out  Y_WIDTH  origin Y presented to drawer
- shapeIndex  out  IDX_WIDTH  slot currently being serviced
- frameBusy  out  1  high whenever state != IDLE
- frameDone  out  1  one-cycle pulse when frame walk completes
- frameOverrun  out  1  sticky: frameTick arrived while busy
- timeoutError  out  1  sticky: a slot hit TIMEOUT
- clearError  in  1  clears both sticky flags

Behaviour:
- Reset (synchronous, priority over all else): state=IDLE; shapeIndex=0; startX=0; startY=0; snapshots=0; timer=0; all 1-bit outputs 0.
- States and transitions:
  - IDLE: on frameTick, latch slotValid/slotX/slotY into snapshot registers, set shapeIndex=0, go to SELECT.
  - SELECT:
    - if shapeIndex==NUM_SHAPES, go to FINISH;
    - else if snapValid[shapeIndex], go to LOAD;
    - else shapeIndex+1, stay in SELECT (one cycle per skipped slot).
  - LOAD: startX/startY <= snapshot[shapeIndex]. Go to START when shapeDone==1; otherwise wait (timer runs).
  - START: startingAddressLoaded=1 for exactly this cycle. Clear timer, go to WAIT_ACK.
  - WAIT_ACK: on shapeDone==0 go to WAIT_DONE (timer keeps running).
  - WAIT_DONE: on shapeDone==1 go to NEXT.
  - NEXT: shapeIndex+1, timer=0, go to SELECT.
  - FINISH: frameDone=1 for one cycle, go to IDLE. shapeIndex stays at NUM_SHAPES until the next frame.
- Outputs:
  - startingAddressLoaded and frameDone are decoded from state.
  - frameBusy = (state != IDLE).
  - startX, startY and shapeIndex are registered and hold between updates.
- Timer:
  - Counts in LOAD, WAIT_ACK and WAIT_DONE. It is not cleared between LOAD and START; START clears it.
  - If the exit condition is not met on the TIMEOUT-th consecutive counted cycle, set timeoutError and go to NEXT. The slot is abandoned and the walk continues.
  - Timer width is ceil(log2(TIMEOUT+1)); no wrap is possible.
- Snapshot: slot inputs are ignored after frame acceptance. Input changes mid-frame do not affect the current frame.
- frameTick while busy is ignored and sets frameOverrun. frameTick in the same cycle as FINISH is also an overrun; the next frame needs a tick while in IDLE.
- clearError clears both sticky flags. If clearError and a new set event occur in the same cycle, the set wins.
- Latency:
  - frameTick (cycle 0) → SELECT at cycle 1.
  - First valid slot 0 with drawer idle: LOAD at cycle 2, startingAddressLoaded high at cycle 3.
  - Empty frame (no valid slots): frameDone at cycle 1+NUM_SHAPES+1.
- Reset asserted mid-frame aborts immediately. No further start pulse is issued and no frameDone is pulsed.

Test Plan:
- Reset then idle, NUM_SHAPES=4, shapeDone=1 → all outputs 0, shapeIndex=0, no start pulse over 20 cycles.
- slotValid=4'b0101, X0=10,Y0=20,X2=100,Y2=50; drawer model drops done 1 cycle after start and raises it 5 cycles later → two start pulses with (10,20) then (100,50), shapeIndex 0 then 2; frameDone exactly once; frameBusy high from cycle 1 to the FINISH cycle.
- slotValid=0 with a frameTick → no start pulse; frameDone at cycle 6 after the tick.
- TIMEOUT=8, drawer holds shapeDone=1 after start (never acks), slotValid=4'b0011 → timeoutError set 8 cycles after START for slot 0; slot 1 still started; frameDone pulses; clearError clears the flag.
- Second frameTick during a busy frame, and slotX changed mid-frame → frameOverrun=1; drawn coordinates equal the values snapshotted at acceptance; no extra frame runs.
- Reset asserted in WAIT_DONE → next cycle state IDLE, frameBusy=0; no start or frameDone pulse afterwards until a new frameTick.

Source files
------------

// File: rtl/shape_dispatcher_if.sv
// Bus between the frame dispatcher, the game/note-lane slot table and the pixel-drawing FSM.
// The dispatcher sits on the slave modport; the game logic and drawer together form the master side.
interface shape_dispatcher_if #(
    parameter int NUM_SHAPES = 4,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7,
    parameter int IDX_WIDTH  = 3
);
    // Drawer handshake: startingAddressLoaded is a one-cycle start with startX/startY/shapeIndex
    // already stable; the drawer acknowledges by dropping shapeDone and finishes by raising it again.
    logic                          frameTick;
    logic [NUM_SHAPES-1:0]         slotValid;
    logic [NUM_SHAPES*X_WIDTH-1:0] slotX;
    logic [NUM_SHAPES*Y_WIDTH-1:0] slotY;
    logic                          shapeDone;
    logic                          clearError;
    logic                          startingAddressLoaded;
    logic [X_WIDTH-1:0]            startX;
    logic [Y_WIDTH-1:0]            startY;
    logic [IDX_WIDTH-1:0]          shapeIndex;
    logic                          frameBusy;
    logic                          frameDone;
    logic                          frameOverrun;
    logic                          timeoutError;

    modport slave (
        input  frameTick, slotValid, slotX, slotY, shapeDone, clearError,
        output startingAddressLoaded, startX, startY, shapeIndex,
               frameBusy, frameDone, frameOverrun, timeoutError
    );

    modport master (
        output frameTick, slotValid, slotX, slotY, shapeDone, clearError,
        input  startingAddressLoaded, startX, startY, shapeIndex,
               frameBusy, frameDone, frameOverrun, timeoutError
    );
endinterface

// File: rtl/shape_dispatcher.sv
// Per-frame walker: snapshots the slot table on frameTick and starts the drawer once per valid slot,
// in ascending index order, with a per-slot watchdog and sticky overrun/timeout flags.
module shape_dispatcher #(
    parameter int NUM_SHAPES = 4,
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 7,
    parameter int TIMEOUT    = 4095,
    parameter int IDX_WIDTH  = 3
) (
    input  logic               clock,
    input  logic               reset,
    shape_dispatcher_if.slave  bus,
    output logic [2:0]         dbg_state
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]        T_LAST  = TW'(TIMEOUT - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_END = IDX_WIDTH'(NUM_SHAPES);

    typedef enum logic [2:0] {
        IDLE, SELECT, LOAD, START, WAIT_ACK, WAIT_DONE, NEXT, FINISH
    } state_e;

    state_e                        state_q, state_d;
    logic [IDX_WIDTH-1:0]          idx_q, idx_d;
    logic [X_WIDTH-1:0]            x_q, x_d;
    logic [Y_WIDTH-1:0]            y_q, y_d;
    logic [NUM_SHAPES-1:0]         snap_valid_q, snap_valid_d;
    logic [NUM_SHAPES*X_WIDTH-1:0] snap_x_q, snap_x_d;
    logic [NUM_SHAPES*Y_WIDTH-1:0] snap_y_q, snap_y_d;
    logic [TW-1:0]                 timer_q, timer_d;
    logic                          overrun_q, overrun_d;
    logic                          timeout_q, timeout_d;

    logic                          sel_valid;
    logic [X_WIDTH-1:0]            sel_x;
    logic [Y_WIDTH-1:0]            sel_y;
    logic                          timer_expired;
    logic [TW-1:0]                 timer_inc;

    always_comb begin
        sel_valid = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NUM_SHAPES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                sel_valid = snap_valid_q[i];
                sel_x     = snap_x_q[i*X_WIDTH +: X_WIDTH];
                sel_y     = snap_y_q[i*Y_WIDTH +: Y_WIDTH];
            end
        end
    end

    // Saturating so a late ack that crosses the limit in WAIT_ACK cannot wrap in WAIT_DONE.
    assign timer_expired = (timer_q >= T_LAST);
    assign timer_inc     = timer_expired ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        snap_valid_d = snap_valid_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        timer_d      = timer_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;

        // Clear first so a same-cycle set event below wins.
        if (bus.clearError) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (bus.frameTick && state_q != IDLE) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.frameTick) begin
                    snap_valid_d = bus.slotValid;
                    snap_x_d     = bus.slotX;
                    snap_y_d     = bus.slotY;
                    idx_d        = '0;
                    state_d      = SELECT;
                end
            end
            SELECT: begin
                if (idx_q == IDX_END)  state_d = FINISH;
                else if (sel_valid)    state_d = LOAD;
                else                   idx_d   = idx_q + 1'b1;
            end
            LOAD: begin
                x_d     = sel_x;
                y_d     = sel_y;
                timer_d = timer_inc;
                if (bus.shapeDone) state_d = START;
                else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = NEXT;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                timer_d = timer_inc;
                if (!bus.shapeDone) state_d = WAIT_DONE;
                else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = NEXT;
                end
            end
            WAIT_DONE: begin
                timer_d = timer_inc;
                if (bus.shapeDone) state_d = NEXT;
                else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = NEXT;
                end
            end
            NEXT: begin
                idx_d   = idx_q + 1'b1;
                timer_d = '0;
                state_d = SELECT;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            snap_valid_q <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            timer_q      <= '0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            snap_valid_q <= snap_valid_d;
            snap_x_q     <= snap_x_d;
            snap_y_q     <= snap_y_d;
            timer_q      <= timer_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.startingAddressLoaded = (state_q == START);
    assign bus.frameDone             = (state_q == FINISH);
    assign bus.frameBusy             = (state_q != IDLE);
    assign bus.startX                = x_q;
    assign bus.startY                = y_q;
    assign bus.shapeIndex            = idx_q;
    assign bus.frameOverrun          = overrun_q;
    assign bus.timeoutError          = timeout_q;
    assign dbg_state                 = state_q;
endmodule

// File: tb/tb_shape_dispatcher.sv
// Bench for shape_dispatcher: directed frames against a slot-walk timing model, a start-pulse
// scoreboard, a reactive drawer, and literal pins on key cycle counts.
module tb_shape_dispatcher;
    localparam int NS = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int TO = 8;
    localparam int IW = 3;
    localparam int EW = IW + XW + YW;
    localparam int DRAW_SVC = 6;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    shape_dispatcher_if #(.NUM_SHAPES(NS), .X_WIDTH(XW), .Y_WIDTH(YW), .IDX_WIDTH(IW)) bus ();

    shape_dispatcher #(
        .NUM_SHAPES(NS), .X_WIDTH(XW), .Y_WIDTH(YW), .TIMEOUT(TO), .IDX_WIDTH(IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            checks = 0;
    int            failures = 0;
    int            tick_cyc = 0;
    int            exp_done_rel = 0;
    bit            expect_done = 1'b0;
    bit            tracking = 1'b0;
    int            done_seen = 0;
    int            done_before = 0;
    int            first_start_rel = -1;
    int            last_done_rel = -1;
    int            drawer_mode = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - tick_cyc < r) next_cycle();
    endtask

    // ---------------- drawer model ----------------
    // Mode 0: drop done one cycle after the start, raise it five cycles later. Mode 1: never ack.
    initial begin
        bus.shapeDone = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.startingAddressLoaded && drawer_mode == 0) begin
                @(posedge clock);
                #1 bus.shapeDone = 1'b0;
                repeat (5) @(posedge clock);
                #1 bus.shapeDone = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    int            mon_rel;
    logic [EW-1:0] mon_e;
    int            mon_ec;
    bit            mon_busy;
    initial begin
        forever begin
            @(negedge clock);
            mon_rel = cyc - tick_cyc;
            if (bus.startingAddressLoaded) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "start_unexpected", mon_rel, -1);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ec = exp_cyc_q.pop_front();
                    check(bus.shapeIndex == mon_e[EW-1 -: IW], "start_index", bus.shapeIndex, mon_e[EW-1 -: IW]);
                    check(bus.startX == mon_e[YW +: XW], "start_x", bus.startX, mon_e[YW +: XW]);
                    check(bus.startY == mon_e[YW-1:0], "start_y", bus.startY, mon_e[YW-1:0]);
                    check(mon_rel == mon_ec, "start_cycle", mon_rel, mon_ec);
                    if (first_start_rel < 0) first_start_rel = mon_rel;
                end
            end
            if (bus.frameDone) begin
                done_seen++;
                if (!expect_done) begin
                    check(1'b0, "done_unexpected", mon_rel, -1);
                end else begin
                    check(mon_rel == exp_done_rel, "done_cycle", mon_rel, exp_done_rel);
                    last_done_rel = mon_rel;
                    expect_done   = 1'b0;
                end
            end
            if (tracking) begin
                mon_busy = (mon_rel >= 1) && (mon_rel <= exp_done_rel);
                check(bus.frameBusy == mon_busy, "frame_busy", bus.frameBusy, mon_busy);
                if (mon_rel > exp_done_rel) tracking = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Model: tick->SELECT is 1 cycle; a skipped slot costs 1; a valid slot costs
    // SELECT+LOAD+START+service+NEXT = 4+service, its start lands 2 cycles after its SELECT;
    // the closing SELECT costs 1 and FINISH follows.
    task automatic start_frame(input logic [NS-1:0] v, input logic [NS*XW-1:0] xs,
                               input logic [NS*YW-1:0] ys, input int mode);
        int r;
        drawer_mode   = mode;
        bus.slotValid = v;
        bus.slotX     = xs;
        bus.slotY     = ys;
        r = 1;
        for (int i = 0; i < NS; i++) begin
            if (v[i]) begin
                exp_q.push_back({IW'(i), xs[i*XW +: XW], ys[i*YW +: YW]});
                exp_cyc_q.push_back(r + 2);
                r += 4 + ((mode == 1) ? TO : DRAW_SVC);
            end else begin
                r += 1;
            end
        end
        exp_done_rel    = r + 1;
        expect_done     = 1'b1;
        first_start_rel = -1;
        last_done_rel   = -1;
        done_before     = done_seen;
        bus.frameTick   = 1'b1;
        tick_cyc        = cyc;
        tracking        = 1'b1;
        next_cycle();
        bus.frameTick   = 1'b0;
    endtask

    task automatic wait_done(input int lit_done, input int lit_first);
        int n;
        n = 0;
        while (done_seen == done_before && n < 200) begin
            next_cycle();
            n++;
        end
        check(n < 200, "done_wait_bound", n, 200);
        check(last_done_rel == lit_done, "done_literal", last_done_rel, lit_done);
        if (lit_first >= 0)
            check(first_start_rel == lit_first, "first_start_literal", first_start_rel, lit_first);
        check(exp_q.size() == 0, "starts_missing", exp_q.size(), 0);
        next_cycle();
        next_cycle();
    endtask

    task automatic pulse_clear();
        bus.clearError = 1'b1;
        next_cycle();
        bus.clearError = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int done_snap;
    initial begin
        reset          = 1'b1;
        bus.frameTick  = 1'b0;
        bus.clearError = 1'b0;
        bus.slotValid  = '0;
        bus.slotX      = '0;
        bus.slotY      = '0;
        repeat (3) next_cycle();
        check(bus.frameBusy == 1'b0, "reset_busy", bus.frameBusy, 0);
        reset = 1'b0;

        // Idle after reset: everything zero, no pulses.
        for (int i = 0; i < 20; i++) begin
            check({bus.frameBusy, bus.startingAddressLoaded, bus.frameDone, bus.frameOverrun,
                   bus.timeoutError, bus.shapeIndex, bus.startX, bus.startY} == '0,
                  "idle_outputs",
                  {bus.frameBusy, bus.startingAddressLoaded, bus.frameDone, bus.frameOverrun,
                   bus.timeoutError, bus.shapeIndex, bus.startX, bus.startY}, 0);
            next_cycle();
        end

        // Two valid slots (0 and 2); invalid slots carry junk that must never be presented.
        start_frame(4'b0101, {8'd55, 8'd100, 8'd77, 8'd10}, {7'd11, 7'd50, 7'd33, 7'd20}, 0);
        wait_done(24, 3);
        check(bus.shapeIndex == 3'd4, "index_after_frame", bus.shapeIndex, 4);

        // Empty frame, plus a tick landing exactly on the FINISH cycle.
        start_frame(4'b0000, '0, '0, 0);
        wait_rel(6);
        bus.frameTick = 1'b1;
        next_cycle();
        bus.frameTick = 1'b0;
        wait_done(6, -1);
        check(bus.frameOverrun == 1'b1, "finish_tick_overrun", bus.frameOverrun, 1);
        done_snap = done_seen;
        repeat (15) next_cycle();
        check(done_seen == done_snap, "no_frame_after_finish_tick", done_seen, done_snap);
        pulse_clear();
        check(bus.frameOverrun == 1'b0, "clear_overrun", bus.frameOverrun, 0);

        // Drawer never acknowledges: each valid slot times out after TO counted cycles.
        start_frame(4'b0011, {8'd0, 8'd0, 8'd2, 8'd1}, {7'd0, 7'd0, 7'd4, 7'd3}, 1);
        wait_rel(3 + TO);
        check(bus.timeoutError == 1'b0, "timeout_early", bus.timeoutError, 0);
        next_cycle();
        check(bus.timeoutError == 1'b1, "timeout_set", bus.timeoutError, 1);
        wait_done(28, 3);
        check(bus.timeoutError == 1'b1, "timeout_sticky", bus.timeoutError, 1);
        check(bus.frameOverrun == 1'b0, "timeout_no_overrun", bus.frameOverrun, 0);
        pulse_clear();
        check(bus.timeoutError == 1'b0, "clear_timeout", bus.timeoutError, 0);
        drawer_mode = 0;

        // Mid-frame input changes and a second tick together with clearError.
        start_frame(4'b0001, {8'd0, 8'd0, 8'd0, 8'd33}, {7'd0, 7'd0, 7'd0, 7'd44}, 0);
        wait_rel(2);
        bus.slotValid = 4'b1111;
        bus.slotX     = {8'd99, 8'd99, 8'd99, 8'd99};
        bus.slotY     = {7'd99, 7'd99, 7'd99, 7'd99};
        wait_rel(5);
        bus.frameTick  = 1'b1;
        bus.clearError = 1'b1;
        next_cycle();
        bus.frameTick  = 1'b0;
        bus.clearError = 1'b0;
        check(bus.frameOverrun == 1'b1, "overrun_set_wins", bus.frameOverrun, 1);
        wait_done(15, 3);
        done_snap = done_seen;
        repeat (20) next_cycle();
        check(done_seen == done_snap, "no_extra_frame", done_seen, done_snap);
        check(bus.shapeIndex == 3'd4, "no_extra_frame_index", bus.shapeIndex, 4);
        bus.slotValid = '0;
        pulse_clear();

        // Reset while the drawer is busy (WAIT_DONE) aborts the frame outright.
        start_frame(4'b0001, {8'd0, 8'd0, 8'd0, 8'd7}, {7'd0, 7'd0, 7'd0, 7'd9}, 0);
        wait_rel(6);
        check(bus.frameBusy == 1'b1, "busy_before_reset", bus.frameBusy, 1);
        expect_done = 1'b0;
        tracking    = 1'b0;
        done_snap   = done_seen;
        reset       = 1'b1;
        next_cycle();
        reset       = 1'b0;
        check(bus.frameBusy == 1'b0, "abort_busy", bus.frameBusy, 0);
        check(bus.shapeIndex == '0, "abort_index", bus.shapeIndex, 0);
        check({bus.startX, bus.startY} == '0, "abort_origin", {bus.startX, bus.startY}, 0);
        for (int i = 0; i < 20; i++) begin
            check({bus.frameBusy, bus.startingAddressLoaded, bus.frameDone} == 3'b000,
                  "abort_quiet", {bus.frameBusy, bus.startingAddressLoaded, bus.frameDone}, 0);
            next_cycle();
        end
        check(done_seen == done_snap, "abort_no_done", done_seen, done_snap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
